booth_mul_arbiter: RTL and testbench
====================================

// Module: booth_mul_arbiter
// PURPOSE
//  Shares one booth_top multiplier core between NUM_REQ requesters. Round-robin arbitration,
//  valid/ready request and response handshakes. Sequences the core's start/operand inputs.
//  Times the core's fixed latency and returns the product tagged with the requester id.
//  Sits between the client blocks and a single booth_top instance.
// PARAMETERS
//  NUM_REQ     4    number of requesters (2..8)
//  WIDTH       16   operand width, signed two's complement
//  MUL_CYCLES  17   clk cycles from mul_start rising until mul_product is valid
// PORTS
//  clk           in   1                 single clock, rising edge
//  rst           in   1                 asynchronous, active-high reset
//  req_valid     in   NUM_REQ           per-requester request valid
//  req_ready     out  NUM_REQ           per-requester accept (one-hot or zero)
//  req_a         in   NUM_REQ*WIDTH     multiplicands, requester i at [i*WIDTH +: WIDTH]
//  req_b         in   NUM_REQ*WIDTH     multiplicators, same packing
//  resp_valid    out  1                 response valid
//  resp_ready    in   1                 response accept
//  resp_id       out  clog2(NUM_REQ)    index of the requester owning the response
//  resp_product  out  2*WIDTH+1         signed product
//  mul_start     out  1                 to booth_top start; held high for a whole operation
//  mul_a, mul_b  out  WIDTH             to booth_top multiplicand_in / multiplicator_in
//  mul_product   in   2*WIDTH+1         from booth_top multiplication
// BEHAVIOUR
//  Reset (async, immediate):
//   - Outputs: state=IDLE; resp_valid=0, resp_id=0, resp_product=0; mul_start=0, mul_a=mul_b=0.
//   - Internal: cycle counter=0; rr pointer=NUM_REQ-1, so requester 0 has top priority first.
//   - Reset mid-operation aborts with no response; the core sees start fall.
//  FSM states: IDLE, BUSY, RESP.
//   IDLE
//    - mul_start=0.
//    - Winner = first asserted req_valid, scanning from pointer+1 upward with wrap.
//    - req_ready[winner]=1 combinationally; every other req_ready bit stays 0.
//    - With no req_valid, req_ready=0.
//    - On that edge: latch req_a/req_b of the winner into mul_a/mul_b; latch id; pointer=winner.
//    - Next state BUSY; counter=MUL_CYCLES-1.
//   BUSY
//    - mul_start=1; mul_a/mul_b held stable.
//    - Counter decrements each cycle.
//    - When counter==0: latch resp_product<=mul_product and resp_id<=id; mul_start<=0; go to RESP.
//   RESP
//    - resp_valid=1; resp_product and resp_id held stable.
//    - Go to IDLE on the edge where resp_ready=1.
//    - Stalls indefinitely otherwise; no new grant is made while in RESP.
//  Handshake rules:
//   - A request transfers when req_valid[i]&&req_ready[i].
//   - Requesters hold valid and operands until accepted.
//   - Deasserting req_valid before acceptance is legal; that request is simply not served.
//   - req_ready is never asserted outside IDLE.
//  Timing:
//   - Request accepted at cycle T. mul_start is high from T+1 through T+MUL_CYCLES.
//   - resp_valid rises at T+MUL_CYCLES+1.
//   - Minimum per-operation period is MUL_CYCLES+2 (when resp_ready is held high).
//   - mul_start is therefore low for >=1 cycle between operations, which re-arms the core.
//  Arithmetic: the product passes through bit-exact. No sign extension, truncation or rounding.
//  Fairness: the requester just granted has lowest priority next time. With all requesting,
//   grants run 0,1,2,3,0,... No starvation.
// STRUCTURE
//  - Header booth_defs.vh: WIDTH, PROD_W=2*WIDTH+1, state encodings ST_IDLE/ST_BUSY/ST_RESP.
//  - One sub-module booth_rr_pick. Combinational: inputs req vector and pointer; outputs
//    one-hot grant, grant index and any_req.
//  - Top module holds the FSM, counter, operand/response registers and the pointer.
// TESTING (bench instantiates booth_mul_arbiter + booth_top, clk period 100ns)
//  1. Reset mid-BUSY, then release.
//     -> mul_start=0 and resp_valid=0 at once; no response ever emitted.
//     -> The next grant goes to requester 0.
//  2. Requester 2 only, a=b=16'hD4C9 (-11063), resp_ready=1.
//     -> resp_id=2, resp_product=33'sd122389969, MUL_CYCLES+1 cycles after accept.
//  3. Requesters 0..3 all valid continuously, resp_ready=1.
//     -> Grant order 0,1,2,3,0. Exactly one req_ready bit per IDLE cycle.
//  4. Requester 1, a=16'hD4C9, b=16'h6572 (25970); resp_ready held 0 for 10 cycles.
//     -> resp_product=-287306110 held stable throughout the stall.
//     -> Requester 3 sees no req_ready during the stall.
//  5. Requester 0 drops req_valid while another operation is BUSY.
//     -> It is never granted; the pointer and order of the remaining requesters are unaffected.
//  6. Back-to-back single requester, 3 operations.
//     -> mul_start low for exactly 2 cycles between runs (RESP, then IDLE).
//     -> Period = MUL_CYCLES+2.

Source files
------------

// File: rtl/booth_mul_arbiter_pkg.sv
// Shared constants for the booth multiplier arbiter: FSM encodings and
// a helper that sizes the latency counter.
package booth_mul_arbiter_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_BUSY = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

  // Bits needed to hold values 0..cycles-1, never less than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/booth_rr_pick.sv
// Combinational round-robin picker: the first asserted request found when
// scanning upward from ptr+1 (with wrap) wins, so the last winner ranks last.
module booth_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  // Scan all N positions starting just after the pointer; keep the first hit.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] idx;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IDX_W'((int'(ptr) + off) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one booth_top multiplier core among NUM_REQ requesters.
// Round-robin grant in IDLE, fixed-latency wait in BUSY while mul_start is
// held high, then the tagged product is presented in RESP until accepted.
module booth_mul_arbiter
  import booth_mul_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 17,
  localparam int ID_W      = $clog2(NUM_REQ),
  localparam int PROD_W    = 2 * WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [PROD_W-1:0]        resp_product,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [PROD_W-1:0]        mul_product
);

  localparam int CNT_W = cnt_width(MUL_CYCLES);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic               mul_start_q, mul_start_d;
  logic [PROD_W-1:0]  resp_product_q, resp_product_d;
  logic [ID_W-1:0]    resp_id_q, resp_id_d;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_req;

  booth_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  // Grants are only offered while idle; at most one bit is ever set.
  assign req_ready = (state_q == ST_IDLE) ? grant : '0;

  // Next-state logic for the FSM, latency counter and datapath registers.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ptr_d          = ptr_q;
    id_d           = id_q;
    mul_a_d        = mul_a_q;
    mul_b_d        = mul_b_q;
    mul_start_d    = mul_start_q;
    resp_product_d = resp_product_q;
    resp_id_d      = resp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          mul_a_d     = req_a[int'(grant_idx)*WIDTH +: WIDTH];
          mul_b_d     = req_b[int'(grant_idx)*WIDTH +: WIDTH];
          id_d        = grant_idx;
          ptr_d       = grant_idx;
          cnt_d       = CNT_W'(MUL_CYCLES - 1);
          mul_start_d = 1'b1;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          resp_product_d = mul_product;
          resp_id_d      = id_q;
          mul_start_d    = 1'b0;
          state_d        = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        mul_start_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any operation and drops mul_start at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      ptr_q          <= ID_W'(NUM_REQ - 1);
      id_q           <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      mul_start_q    <= 1'b0;
      resp_product_q <= '0;
      resp_id_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ptr_q          <= ptr_d;
      id_q           <= id_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      mul_start_q    <= mul_start_d;
      resp_product_q <= resp_product_d;
      resp_id_q      <= resp_id_d;
    end
  end

  assign resp_valid   = (state_q == ST_RESP);
  assign resp_id      = resp_id_q;
  assign resp_product = resp_product_q;
  assign mul_start    = mul_start_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter with a behavioural stand-in for the booth core
// whose product only becomes correct after the core's fixed latency.
module tb_booth_mul_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int WIDTH      = 16;
  localparam int MUL_CYCLES = 17;
  localparam int ID_W       = 2;
  localparam int PROD_W     = 2 * WIDTH + 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic [PROD_W-1:0]        resp_product;
  logic                     mul_start;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic [PROD_W-1:0]        mul_product;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int accept_cyc;
  int last_fall = -1;
  int last_gap  = -1;
  int core_cnt;

  booth_mul_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_product  (mul_product)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Exact signed product, truncated to the port width (always fits).
  function automatic logic [PROD_W-1:0] ref_prod(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[PROD_W-1:0];
  endfunction

  // Core stand-in: counts edges with start high; product is garbage until the latency elapses.
  always @(posedge clk or posedge rst) begin
    if (rst)            core_cnt <= 0;
    else if (mul_start) core_cnt <= core_cnt + 1;
    else                core_cnt <= 0;
  end

  assign mul_product = (mul_start && core_cnt >= MUL_CYCLES - 1) ? ref_prod(mul_a, mul_b)
                                                                 : 33'h1_5A5A_5A5A;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction for requester exp_id: grant, latency, product, stall, release.
  task automatic serve(input int exp_id, input int stall, input bit keep,
                       input logic [PROD_W-1:0] exp_prod);
    int               wait_n;
    int               lat;
    int               hi;
    int               rise;
    bit               opnd_bad;
    bit               rdy_bad;
    bit               stall_bad;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic [PROD_W-1:0] held;
    ea         = req_a[exp_id*WIDTH +: WIDTH];
    eb         = req_b[exp_id*WIDTH +: WIDTH];
    resp_ready = (stall == 0);
    wait_n     = 0;
    while (req_ready == '0 && wait_n < 60) begin
      @(negedge clk);
      wait_n++;
    end
    check("grant", 64'(req_ready), 64'(1) << exp_id);
    if (req_ready == '0) return;
    accept_cyc = cyc;
    @(negedge clk);
    if (!keep) req_valid[exp_id] = 1'b0;
    rise     = cyc;
    lat      = 1;
    hi       = 0;
    opnd_bad = 1'b0;
    rdy_bad  = 1'b0;
    while (!resp_valid && lat < 60) begin
      if (mul_start) hi++;
      if (mul_a !== ea || mul_b !== eb) opnd_bad = 1'b1;
      if (req_ready !== '0) rdy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (last_fall >= 0) last_gap = rise - last_fall;
    last_fall = cyc;
    check("resp_latency", 64'(lat), 64'(MUL_CYCLES + 1));
    check("start_high_cycles", 64'(hi), 64'(MUL_CYCLES));
    check("operands_stable", 64'(opnd_bad), 64'(0));
    check("ready_low_busy", 64'(rdy_bad), 64'(0));
    check("start_low_in_resp", 64'(mul_start), 64'(0));
    check("resp_id", 64'(resp_id), 64'(exp_id));
    check("resp_product", 64'(resp_product), 64'(exp_prod));
    held      = resp_product;
    stall_bad = 1'b0;
    for (int i = 0; i < stall; i++) begin
      if (resp_product !== held || resp_valid !== 1'b1 || resp_id !== ID_W'(exp_id) ||
          req_ready !== '0) stall_bad = 1'b1;
      @(negedge clk);
    end
    if (stall > 0) check("stall_stable", 64'(stall_bad), 64'(0));
    resp_ready = 1'b1;
    @(negedge clk);
    check("resp_released", 64'(resp_valid), 64'(0));
  endtask

  initial begin
    #(100 * 30000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1;
    int acc2;
    int ptr_m;
    int pred;
    int mask;
    bit seen;

    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_resp_valid", 64'(resp_valid), 64'(0));
    check("rst_resp_id", 64'(resp_id), 64'(0));
    check("rst_resp_product", 64'(resp_product), 64'(0));
    check("rst_mul_start", 64'(mul_start), 64'(0));
    check("rst_mul_a", 64'(mul_a), 64'(0));
    check("rst_mul_b", 64'(mul_b), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    rst = 1'b0;

    // Reset in the middle of BUSY aborts silently.
    req_a[3*WIDTH +: WIDTH] = 16'h1234;
    req_b[3*WIDTH +: WIDTH] = 16'h0042;
    req_valid = 4'b1000;
    #1;
    check("pre_abort_grant", 64'(req_ready), 64'(4'b1000));
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    check("pre_abort_busy", 64'(mul_start), 64'(1));
    #20 rst = 1'b1;
    #1;
    check("abort_mul_start", 64'(mul_start), 64'(0));
    check("abort_resp_valid", 64'(resp_valid), 64'(0));
    check("abort_mul_a", 64'(mul_a), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (resp_valid || mul_start) seen = 1'b1;
    end
    check("abort_no_response", 64'(seen), 64'(0));

    // All four requesting continuously: grants 0,1,2,3,0, starting with 0 after reset.
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    end
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      serve(k % NUM_REQ, 0, 1'b1,
            ref_prod(req_a[(k % NUM_REQ)*WIDTH +: WIDTH], req_b[(k % NUM_REQ)*WIDTH +: WIDTH]));
    end
    req_valid = '0;
    #1;

    // Requester 1 with a stalled response while requester 3 waits (pointer is 0 here).
    req_a[1*WIDTH +: WIDTH] = 16'hD4C9;
    req_b[1*WIDTH +: WIDTH] = 16'h6572;
    req_a[3*WIDTH +: WIDTH] = 16'h7FFF;
    req_b[3*WIDTH +: WIDTH] = 16'h8000;
    req_valid = 4'b1010;
    #1;
    serve(1, 10, 1'b0, 33'd8302628482);
    serve(3, 0, 1'b0, ref_prod(16'h7FFF, 16'h8000));

    // Requester 2 alone, squaring -11063.
    req_a[2*WIDTH +: WIDTH] = 16'hD4C9;
    req_b[2*WIDTH +: WIDTH] = 16'hD4C9;
    req_valid = 4'b0100;
    #1;
    serve(2, 0, 1'b0, 33'd122389969);

    // Requester 0 withdraws while requester 3 is being served; 1 must come next.
    req_a[0*WIDTH +: WIDTH] = 16'h0001;
    req_b[0*WIDTH +: WIDTH] = 16'h0001;
    req_a[1*WIDTH +: WIDTH] = 16'h8000;
    req_b[1*WIDTH +: WIDTH] = 16'h8000;
    req_a[3*WIDTH +: WIDTH] = 16'hFFFF;
    req_b[3*WIDTH +: WIDTH] = 16'h0003;
    req_valid = 4'b1011;
    #1;
    fork
      serve(3, 0, 1'b0, ref_prod(16'hFFFF, 16'h0003));
      begin
        repeat (5) @(negedge clk);
        req_valid[0] = 1'b0;
      end
    join
    serve(1, 0, 1'b0, ref_prod(16'h8000, 16'h8000));
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (req_ready !== '0) seen = 1'b1;
    end
    check("withdrawn_never_granted", 64'(seen), 64'(0));

    // Back-to-back single requester: period MUL_CYCLES+2, start low for 2 cycles.
    req_a[2*WIDTH +: WIDTH] = 16'h0101;
    req_b[2*WIDTH +: WIDTH] = 16'hFF00;
    req_valid = 4'b0100;
    #1;
    serve(2, 0, 1'b1, ref_prod(16'h0101, 16'hFF00));
    acc1 = accept_cyc;
    serve(2, 0, 1'b1, ref_prod(16'h0101, 16'hFF00));
    acc2 = accept_cyc;
    check("b2b_period_1", 64'(acc2 - acc1), 64'(MUL_CYCLES + 2));
    check("b2b_start_gap_1", 64'(last_gap), 64'(2));
    serve(2, 0, 1'b0, ref_prod(16'h0101, 16'hFF00));
    check("b2b_period_2", 64'(accept_cyc - acc2), 64'(MUL_CYCLES + 2));
    check("b2b_start_gap_2", 64'(last_gap), 64'(2));

    // Random masks and operands against the round-robin reference.
    ptr_m = 2;
    for (int n = 0; n < 16; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      end
      mask = int'($urandom_range(1, 15));
      req_valid = NUM_REQ'(mask);
      #1;
      pred = -1;
      for (int off = 1; off <= NUM_REQ; off++) begin
        if (pred < 0 && mask[(ptr_m + off) % NUM_REQ]) pred = (ptr_m + off) % NUM_REQ;
      end
      serve(pred, int'($urandom_range(0, 3)), 1'b0,
            ref_prod(req_a[pred*WIDTH +: WIDTH], req_b[pred*WIDTH +: WIDTH]));
      req_valid = '0;
      #1;
      ptr_m = pred;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
